// File: rtl/demux_route_buffer.sv
// Registered 1-to-4 routing stage: one-entry holding register per lane with
// independent valid/ready per lane, so a stalled lane never blocks the others.
module demux_route_buffer #(
  parameter int unsigned BITS = 4
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [BITS-1:0] DATA,
  input  logic [1:0]      SELECT,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic [BITS-1:0] A,
  output logic [BITS-1:0] B,
  output logic [BITS-1:0] C,
  output logic [BITS-1:0] D,
  output logic [3:0]      VALID,
  input  logic [3:0]      READY,
  output logic [2:0]      OCCUPANCY
);

  localparam int unsigned LANES = 4;
  localparam int unsigned OCC_W = 3;

  logic [LANES-1:0][BITS-1:0] r_q, r_d;
  logic [LANES-1:0]           v_q, v_d;
  logic [OCC_W-1:0]           occ_q, occ_d;
  logic                       accept_c;

  // Selected lane can take a word when empty or draining this cycle.
  always_comb begin
    IN_READY = ~v_q[SELECT] | READY[SELECT];
    accept_c = IN_VALID & IN_READY;
  end

  // Per-lane refill/drain; an accept on a draining lane is a pass-through.
  always_comb begin
    r_d   = r_q;
    v_d   = v_q;
    occ_d = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (accept_c && (SELECT == 2'(k))) begin
        r_d[k] = DATA;
        v_d[k] = 1'b1;
      end else if (v_q[k] && READY[k]) begin
        v_d[k] = 1'b0;
      end
    end
    for (int k = 0; k < int'(LANES); k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_q   <= '0;
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      r_q   <= r_d;
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

  assign A         = r_q[0];
  assign B         = r_q[1];
  assign C         = r_q[2];
  assign D         = r_q[3];
  assign VALID     = v_q;
  assign OCCUPANCY = occ_q;

endmodule

// File: tb/tb_demux_route_buffer.sv
// Self-checking bench for demux_route_buffer: lane model checked every
// negative clock edge, plus hand-computed expectations at key points.
module tb_demux_route_buffer;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic [3:0] DATA = '0;
  logic [1:0] SELECT = '0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [3:0] A, B, C, D;
  logic [3:0] VALID;
  logic [3:0] READY = '0;
  logic [2:0] OCCUPANCY;

  int errors = 0;
  int checks = 0;

  demux_route_buffer #(.BITS(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DATA(DATA), .SELECT(SELECT),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .C(C), .D(D),
    .VALID(VALID), .READY(READY), .OCCUPANCY(OCCUPANCY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lane model: each lane is a slot that empties when its consumer takes it,
  // and a new word lands only in a slot that is empty after that.
  logic [3:0] m_data [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  bit         m_full [4] = '{0, 0, 0, 0};

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < 4; k++) begin
        m_data[k] = 4'h0;
        m_full[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++)
        if (READY[k]) m_full[k] = 0;
      if (IN_VALID && !m_full[SELECT]) begin
        m_data[SELECT] = DATA;
        m_full[SELECT] = 1;
      end
    end
  end

  function automatic int m_occ();
    int n = 0;
    for (int k = 0; k < 4; k++) n += int'(m_full[k]);
    return n;
  endfunction

  function automatic logic [3:0] m_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_full[k];
    return v;
  endfunction

  // Combinational ready: slot free now, or its consumer takes the word this cycle.
  always @(negedge CLK) begin
    chk("A",         32'(A),         32'(m_data[0]));
    chk("B",         32'(B),         32'(m_data[1]));
    chk("C",         32'(C),         32'(m_data[2]));
    chk("D",         32'(D),         32'(m_data[3]));
    chk("VALID",     32'(VALID),     32'(m_valid()));
    chk("OCCUPANCY", 32'(OCCUPANCY), 32'(m_occ()));
    chk("IN_READY",  32'(IN_READY),  32'(!m_full[SELECT] || READY[SELECT]));
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] r);
    IN_VALID = v;
    SELECT   = s;
    DATA     = d;
    READY    = r;
    #1;
  endtask

  bit stalled;

  initial begin
    #1 RESET_N = 1'b0;
    step();
    step();
    RESET_N = 1'b1;
    #1;
    chk("reset_abcd",  32'({A, B, C, D}), 32'h0);
    chk("reset_valid", 32'(VALID), 32'h0);
    chk("reset_occ",   32'(OCCUPANCY), 32'h0);
    chk("reset_inrdy", 32'(IN_READY), 32'h1);

    // Route 4'hA to lane C with no consumer ready
    drive(1, 2'd2, 4'hA, 4'b0000);
    step();
    chk("route_c",     32'(C), 32'hA);
    chk("route_valid", 32'(VALID), 32'b0100);
    chk("route_occ",   32'(OCCUPANCY), 32'h1);
    chk("route_abd",   32'({A, B, D}), 32'h0);

    // Back-pressure, then pass-through refill
    drive(1, 2'd2, 4'h5, 4'b0000);
    chk("bp_inrdy", 32'(IN_READY), 32'h0);
    step();
    chk("bp_hold_c", 32'(C), 32'hA);
    drive(1, 2'd2, 4'h5, 4'b0100);
    chk("pt_inrdy", 32'(IN_READY), 32'h1);
    step();
    chk("pt_c",     32'(C), 32'h5);
    chk("pt_valid", 32'(VALID), 32'b0100);
    chk("pt_occ",   32'(OCCUPANCY), 32'h1);

    // Other lanes proceed while C stalls
    drive(1, 2'd0, 4'h1, 4'b0000);
    chk("ind_rdy0", 32'(IN_READY), 32'h1);
    step();
    drive(1, 2'd1, 4'h2, 4'b0000);
    chk("ind_rdy1", 32'(IN_READY), 32'h1);
    step();
    drive(1, 2'd3, 4'h3, 4'b0000);
    chk("ind_rdy3", 32'(IN_READY), 32'h1);
    step();
    chk("ind_valid", 32'(VALID), 32'b1111);
    chk("ind_occ",   32'(OCCUPANCY), 32'h4);
    chk("ind_abcd",  32'({A, B, C, D}), 32'h1253);
    drive(1, 2'd1, 4'h7, 4'b0000);
    chk("full_inrdy_lo", 32'(IN_READY), 32'h0);
    drive(1, 2'd1, 4'h7, 4'b0010);
    chk("full_inrdy_hi", 32'(IN_READY), 32'h1);

    // Drain B and D only
    drive(0, 2'd0, 4'h0, 4'b1010);
    step();
    drive(0, 2'd0, 4'h0, 4'b0000);
    chk("drain_valid", 32'(VALID), 32'b0101);
    chk("drain_occ",   32'(OCCUPANCY), 32'h2);
    chk("drain_bd",    32'({B, D}), 32'h23);

    // Refill B and D, then asynchronous reset between edges
    drive(1, 2'd1, 4'h9, 4'b0000);
    step();
    drive(1, 2'd3, 4'hC, 4'b0000);
    step();
    drive(0, 2'd0, 4'h0, 4'b0000);
    chk("refill_valid", 32'(VALID), 32'b1111);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_valid", 32'(VALID), 32'h0);
    chk("arst_occ",   32'(OCCUPANCY), 32'h0);
    chk("arst_abcd",  32'({A, B, C, D}), 32'h0);
    step();
    RESET_N = 1'b1;
    #1;

    // Stream 8 words into lane A with its consumer always ready
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'd0, 4'(i), 4'b0001);
      chk("stream_inrdy", 32'(IN_READY), 32'h1);
      step();
      chk("stream_a",   32'(A), 32'(i));
      chk("stream_occ", 32'(OCCUPANCY), 32'h1);
    end
    drive(0, 2'd0, 4'h0, 4'b0001);
    step();
    chk("stream_end_valid", 32'(VALID), 32'h0);
    chk("stream_end_occ",   32'(OCCUPANCY), 32'h0);

    // Mixed traffic; upstream holds its word while stalled
    stalled = 0;
    for (int i = 0; i < 60; i++) begin
      if (stalled) drive(IN_VALID, SELECT, DATA, 4'($urandom));
      else drive(1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
      stalled = IN_VALID && !IN_READY;
      step();
    end
    drive(0, 2'd0, 4'h0, 4'b0000);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_route_buffer.md
# demux_route_buffer

Registered 1-to-4 routing stage that sits directly upstream of the four-output N-bit demultiplexer consumers: it accepts one BITS-wide word per cycle with a 2-bit destination select under a valid/ready handshake, and parks it in a one-entry holding register for the selected lane (A, B, C, D). Each lane presents its word with its own valid flag until its consumer acknowledges it. The selected word is written only to its own lane, so back-pressure on one destination does not stall traffic to the other three.

## Interface
- BITS, 4, width of each data word and of each lane output.

- CLK  input  1  rising-edge clock for all state.
- RESET_N  input  1  asynchronous, active-low reset.
- DATA  input  BITS  word to route.
- SELECT  input  2  destination lane: 0→A, 1→B, 2→C, 3→D.
- IN_VALID  input  1  DATA/SELECT are valid this cycle.
- IN_READY  output  1  the block accepts the word this cycle (combinational).
- A, B, C, D  output  BITS each  lane holding registers.
- VALID  output  4  per-lane valid flag; bit 0=A, 1=B, 2=C, 3=D.
- READY  input  4  per-lane consumer ready, with the same bit order.
- OCCUPANCY  output  3  registered count of lanes with VALID set (0–4).

One clock; reset is asynchronous and active-low.

## Operation
- Lane k state: register R_k (BITS) and flag V_k. A..D = R_0..R_3, VALID[k] = V_k.
- IN_READY = ~V[SELECT] | READY[SELECT]. The value depends only on the current SELECT lane.
- accept = IN_VALID & IN_READY; drain_k = V_k & READY[k].
- Per lane, each cycle:
  - If accept and SELECT==k: R_k ← DATA, V_k ← 1. A same-cycle drain of lane k is a pass-through refill.
  - Else if drain_k: V_k ← 0. R_k holds its value.
  - Else: hold.
- Lanes other than SELECT are never written by an accept. Their R and V change only through their own drain.
- An R_k whose V_k is 0 keeps its last value. Consumers must qualify the data with VALID.
- OCCUPANCY ← popcount of the next-state V vector.
- READY[k] while V_k=0 has no effect.
- IN_VALID=0 gives no accept, regardless of SELECT.
- Upstream must hold DATA/SELECT stable while IN_VALID=1 and IN_READY=0. IN_VALID must not depend on IN_READY.

## Timing
- Reset (RESET_N low, asynchronous): all R_k=0, VALID=4'b0000, OCCUPANCY=0. IN_READY=1 for any SELECT while reset is held.
- On deassertion, the first accept can occur on the first rising edge with RESET_N high.
- Latency: word accepted at edge n is on its lane output with VALID set from after edge n (one cycle).
- Throughput: one word per cycle, even to a single lane, while that lane's READY stays 1.
- Full lane: if V[SELECT]=1 and READY[SELECT]=0, then IN_READY=0 and no state changes for that lane.
- Simultaneous events:
  - Accept to lane j and drains on any other lanes happen in the same cycle independently.
  - Accept and drain on the same lane: V stays 1, R takes the new DATA, OCCUPANCY is unchanged.
- All four lanes full: OCCUPANCY=4. IN_READY equals READY[SELECT].
- Reset mid-operation: held words are discarded immediately. VALID drops to 0 asynchronously, without waiting for CLK.

## Test plan
- Reset then route: after reset, check A..D=0, VALID=0, OCCUPANCY=0. Send DATA=4'hA, SELECT=2 with READY=0 → next cycle C=4'hA, VALID=4'b0100, OCCUPANCY=1; A, B, D still 0.
- Back-pressure: with lane C full and READY=0, present SELECT=2, DATA=4'h5 → IN_READY=0 and C stays 4'hA. Raise READY[2] → that cycle is a pass-through: C=4'h5, VALID[2] still 1.
- Independence: with lane C full and stalled, send 4'h1/4'h2/4'h3 to SELECT 0/1/3 on consecutive cycles → each accepted with IN_READY=1. Then VALID=4'b1111, OCCUPANCY=4, C still 4'h5.
- Streaming: READY=4'b0001, send 8 consecutive words 0..7 to SELECT=0 → IN_READY stays 1, A follows each word one cycle later, OCCUPANCY stays 1.
- Drain: with all lanes full, set READY=4'b1010 for one cycle with IN_VALID=0 → VALID=4'b0101, OCCUPANCY=2. B and D keep their data values.
- Async reset: with VALID=4'b1111, pulse RESET_N low between clock edges → VALID=0, all outputs 0, and OCCUPANCY=0 before the next edge.
